fifo_singleclock_std_mem: RTL
=============================

Name: fifo_singleclock_std_mem

Overview:
- Synchronous single-clock FIFO with standard (non-FWFT) read characteristics.
- Read data appears on dout one cycle after an accepted rd_en.
- Storage-and-pointer engine that supplies standard-read data upstream of FWFT read adaptation; also usable standalone where a one-cycle read latency is acceptable.
- Inferable RAM array, registered output, occupancy counter, registered status flags.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 32, number of storage entries; any integer >= 2, not restricted to powers of two
PROG_FULL, DEPTH/2, occupancy threshold for prog_full; legal range 1..DEPTH

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
din  input  WIDTH  write data
wr_en  input  1  write request
full  output  1  count == DEPTH
prog_full  output  1  count >= PROG_FULL
dout  output  WIDTH  read data, valid in the cycle after an accepted read
rd_en  input  1  read request
empty  output  1  count == 0
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: wr_en seen while full (see Optional Feature)
underflow  output  1  sticky: rd_en seen while empty (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr=0, rd_ptr=0, count=0, dout=0, empty=1, full=0, prog_full=0, overflow=0, underflow=0. RAM contents are not reset.
- Reset mid-operation discards all stored entries; the first edge after rst is released behaves as an empty FIFO.
- Write accept: wr_acc = wr_en && !full.
  - On accept: mem[wr_ptr] <= din.
  - wr_ptr advances by one and wraps from DEPTH-1 to 0.
- Read accept: rd_acc = rd_en && !empty.
  - On accept: dout <= mem[rd_ptr], visible after this edge (latency 1).
  - rd_ptr advances by one and wraps from DEPTH-1 to 0.
  - Without an accepted read, dout holds its last value.
- Gating uses the registered flags from before the edge:
  - Write while full is dropped even if a read is accepted in the same cycle.
  - Read while empty is ignored even if a write is accepted in the same cycle.
- count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Flags are registered and derived from the next count: empty=(next==0), full=(next==DEPTH), prog_full=(next>=PROG_FULL). All three change on the same edge as count.
- Write-to-read latency: a word written into an empty FIFO at edge N gives empty=0 after N. rd_en in the following cycle is accepted at N+1; data is on dout after N+1.
- No read/write collision on the same entry: a read only targets entries written at an earlier edge.
- No internal state machine beyond the pointer/count registers. Throughput is one write plus one read per cycle.

Optional Feature:
- Macro: FIFO_SINGLECLOCK_ERROR_FLAGS_EN.
- Defined:
  - overflow sets on any edge with wr_en && full.
  - underflow sets on any edge with rd_en && empty.
  - Both are sticky until rst.
  - Rejected operations still have no effect on data, pointers or count.
- Undefined: overflow and underflow are tied to 0 and their logic is not synthesised. Ports remain present so the interface is unchanged.

Test Plan:
- Reset, then idle 5 cycles -> empty=1, full=0, prog_full=0, count=0, dout=0.
- DEPTH=32: write 0x01..0x20 back-to-back, then read 32 back-to-back:
  - count reaches 32 and full=1 after the 32nd write.
  - prog_full=1 from count=16.
  - dout sequence is 0x01..0x20, each one cycle after its rd_en.
  - empty=1 after the last read.
- Full FIFO, wr_en=rd_en=1 with din=0xAA for one cycle -> read accepted, write dropped, count=31, full=0, 0xAA never appears on dout. With the macro defined, overflow=1.
- Empty FIFO, wr_en=rd_en=1 with din=0x55 -> write accepted, read ignored, count=1, dout unchanged. With the macro, underflow=1. The next-cycle read gives dout=0x55.
- DEPTH=5, PROG_FULL=3: run 40 cycles of random wr_en/rd_en against a scoreboard -> order preserved across pointer wrap, count never exceeds 5, prog_full matches count>=3 every cycle.
- Assert rst while count=10 with wr_en=1 -> count=0, empty=1, flags cleared. The next write/read returns the new data, not stale entries.

Source files
------------

// File: rtl/fifo_singleclock_std_mem.sv
// Single-clock FIFO with standard (one-cycle latency) reads, inferable RAM and registered flags.
// Define FIFO_SINGLECLOCK_ERROR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_singleclock_std_mem #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int PROG_FULL = DEPTH / 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             din,
  input  logic                         wr_en,
  output logic                         full,
  output logic                         prog_full,
  output logic [WIDTH-1:0]             dout,
  input  logic                         rd_en,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q;
  logic             empty_q, full_q, prog_full_q;
  logic             wr_acc, rd_acc;

  // Acceptance is gated by the registered flags, so a simultaneous read never
  // frees space for a write (and vice versa) within the same cycle.
  always_comb begin
    wr_acc   = wr_en && !full_q;
    rd_acc   = rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset so it maps onto block/distributed RAM;
  // stale contents are unreachable because the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      prog_full_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == CW'(DEPTH));
      prog_full_q <= (count_d >= CW'(PROG_FULL));
      if (rd_acc) dout_q <= mem_q[rd_ptr_q];
    end
  end

`ifdef FIFO_SINGLECLOCK_ERROR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q  | (wr_en & full_q);
      underflow_q <= underflow_q | (rd_en & empty_q);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign dout      = dout_q;
  assign count     = count_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign prog_full = prog_full_q;

endmodule
